// File: rtl/spu_wb_pkg.sv
// ============================================================================
// spu_wb_pkg: shared types and constants for the SPU writeback arbiter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_wb_pkg;

  // Widest data path the request record carries; DW of the arbiter must not exceed it.
  localparam int WB_DW_MAX = 64;

  localparam logic [4:0] SPU_DEST_REG = 5'd27;

  typedef struct packed {
    logic                 en;
    logic [4:0]           addr;
    logic [WB_DW_MAX-1:0] data;
  } wb_req_t;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] a);
    return 32'd1 << a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spu_wb_fifo.sv
// ============================================================================
// spu_wb_fifo: synchronous FIFO for SPU results, with per-entry valid/addr taps.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [4:0]               push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [4:0]               head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH-1:0][4:0]    entry_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]         mem_data [DEPTH];
  logic [DEPTH-1:0][4:0] mem_addr;
  logic [DEPTH-1:0]      vld;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (do_push) begin
        wptr      <= wptr + AW'(1);
        vld[wptr] <= 1'b1;
      end
      if (do_pop) begin
        rptr      <= rptr + AW'(1);
        vld[rptr] <= 1'b0;
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wptr] <= push_data;
      mem_addr[wptr] <= push_addr;
    end
  end

  assign head_addr   = mem_addr[rptr];
  assign head_data   = mem_data[rptr];
  assign count       = cnt;
  assign entry_valid = vld;
  assign entry_addr  = mem_addr;

endmodule

`default_nettype wire

// File: rtl/spu_wb_arbiter.sv
// ============================================================================
// spu_wb_arbiter: shares the RF write port between writeback and the SPU FIFO,
// with a starvation-forced SPU slot. Optional stats via SPU_WB_STATS_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_wb_arbiter
  import spu_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 8,
  parameter int DW         = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_wr_en,
  input  logic [4:0]             pipe_wr_addr,
  input  logic [DW-1:0]          pipe_wr_data,
  output logic                   pipe_stall,
  input  logic                   spu_valid,
  input  logic [4:0]             spu_addr,
  input  logic [DW-1:0]          spu_data,
  output logic                   spu_ready,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SPU_WB_STATS_EN
  ,
  output logic [15:0]            stat_force_cnt,
  output logic [15:0]            stat_full_cnt
`endif
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  arb_state_t            state;
  arb_state_t            state_nx;
  logic [SW-1:0]         starve_cnt;
  logic [SW-1:0]         starve_nx;
  logic                  pipe_win;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [4:0]            head_addr;
  logic [DW-1:0]         head_data;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_addr;
  logic                  rf_from_spu;
  wb_req_t               win;

  assign spu_ready = !full;

  spu_wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (spu_valid),
    .push_addr   (spu_addr),
    .push_data   (spu_data),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (fifo_count),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
    end
  end

  always_comb begin
    state_nx = NORMAL;
    if (state == NORMAL && pipe_wr_en && !empty &&
        starve_cnt == SW'(MAX_STARVE - 1)) begin
      state_nx = FORCE;
    end
  end

  always_comb begin
    pipe_win   = 1'b0;
    pop        = 1'b0;
    pipe_stall = 1'b0;
    starve_nx  = '0;
    case (state)
      NORMAL: begin
        if (pipe_wr_en) begin
          pipe_win = 1'b1;
          if (!empty) starve_nx = starve_cnt + SW'(1);
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      FORCE: begin
        pop        = 1'b1;
        pipe_stall = pipe_wr_en;
      end
      default: begin
        pipe_win = 1'b0;
      end
    endcase
  end

  always_comb begin
    win = '0;
    if (pipe_win) begin
      win.en   = 1'b1;
      win.addr = pipe_wr_addr;
      win.data = WB_DW_MAX'(pipe_wr_data);
    end else if (pop) begin
      win.en   = 1'b1;
      win.addr = head_addr;
      win.data = WB_DW_MAX'(head_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      rf_from_spu <= 1'b0;
    end else begin
      rf_we       <= win.en;
      rf_waddr    <= win.addr;
      rf_wdata    <= DW'(win.data);
      rf_from_spu <= pop;
    end
  end

  // A popped entry stays flagged while its write is still on rf_*, so decode
  // cannot read the register before the RF has actually been updated.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask = pending_mask | reg_onehot(entry_addr[i]);
    end
    if (rf_from_spu) pending_mask = pending_mask | reg_onehot(rf_waddr);
  end

`ifdef SPU_WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_force_cnt <= '0;
      stat_full_cnt  <= '0;
    end else begin
      if (state == FORCE && stat_force_cnt != 16'hFFFF)
        stat_force_cnt <= stat_force_cnt + 16'd1;
      if (spu_valid && !spu_ready && stat_full_cnt != 16'hFFFF)
        stat_full_cnt <= stat_full_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spu_wb_arbiter.sv
// ============================================================================
// tb_spu_wb_arbiter: directed self-checking bench for spu_wb_arbiter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spu_wb_arbiter;
  import spu_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wr_en = 1'b0;
  logic [4:0]  pipe_wr_addr = '0;
  logic [31:0] pipe_wr_data = '0;
  logic        pipe_stall;
  logic        spu_valid = 1'b0;
  logic [4:0]  spu_addr = '0;
  logic [31:0] spu_data = '0;
  logic        spu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
`ifdef SPU_WB_STATS_EN
  logic [15:0] stat_force_cnt;
  logic [15:0] stat_full_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  spu_wb_arbiter #(.DEPTH(4), .MAX_STARVE(8), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_wr_addr (pipe_wr_addr),
    .pipe_wr_data (pipe_wr_data),
    .pipe_stall   (pipe_stall),
    .spu_valid    (spu_valid),
    .spu_addr     (spu_addr),
    .spu_data     (spu_data),
    .spu_ready    (spu_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
`ifdef SPU_WB_STATS_EN
    ,
    .stat_force_cnt (stat_force_cnt),
    .stat_full_cnt  (stat_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rfv(input logic we, input logic [4:0] a, input logic [31:0] d);
    return 64'({we, a, d});
  endfunction

  int sent;
  int sp;
  int got;
  int pcnt;
  logic acc;

  initial begin
    // Reset state
    #3;
    check("rst_we",    64'(rf_we), 64'd0);
    check("rst_ready", 64'(spu_ready), 64'd1);
    check("rst_mask",  64'(pending_mask), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_stall", 64'(pipe_stall), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset drops an in-flight write at once
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd9; pipe_wr_data = 32'h1234;
    tick();
    pipe_wr_en = 1'b0;
    check("pre_rst_rf", rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd9, 32'h1234));
    #2 rst_n = 1'b0;
    #1 check("async_rst_we", 64'(rf_we), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single SPU result with idle pipe: rf_we two cycles later, mask 2 cycles
    spu_valid = 1'b1; spu_addr = SPU_DEST_REG; spu_data = 32'hDEADBEEF;
    #1 check("single_mask0", 64'(pending_mask), 64'd0);
    tick();
    spu_valid = 1'b0;
    #1;
    check("single_mask1", 64'(pending_mask), 64'h0800_0000);
    check("single_we1",   64'(rf_we), 64'd0);
    tick();
    check("single_rf",    rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd27, 32'hDEADBEEF));
    check("single_mask2", 64'(pending_mask), 64'h0800_0000);
    tick();
    check("single_we3",   64'(rf_we), 64'd0);
    check("single_mask3", 64'(pending_mask), 64'd0);

    // Starvation: pipe busy every cycle, one SPU entry queued in cycle 0
    sent = 0;
    for (int k = 0; k < 12; k++) begin
      spu_valid = (k == 0); spu_addr = 5'd27; spu_data = 32'h1111_1111;
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'(100 + sent);
      #1 check($sformatf("starve_stall_%0d", k), 64'(pipe_stall), 64'(k == 9));
      tick();
      if (k == 9) begin
        check("starve_force_rf", rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd27, 32'h1111_1111));
      end else begin
        check($sformatf("starve_pipe_%0d", k), rfv(rf_we, rf_waddr, rf_wdata),
              rfv(1'b1, 5'd5, 32'(100 + sent)));
        sent++;
      end
    end
    pipe_wr_en = 1'b0; spu_valid = 1'b0;
    tick();

    // FIFO full with 5 SPU results while the pipe is busy
    sp = 0; got = 0; pcnt = 0;
    for (int k = 0; k < 21; k++) begin
      pipe_wr_en = (k <= 10); pipe_wr_addr = 5'd5; pipe_wr_data = 32'h55;
      spu_valid = (sp < 5); spu_addr = 5'(10 + sp); spu_data = 32'(32'hA0 + sp);
      #1;
      if (k == 4) begin
        check("full_ready4", 64'(spu_ready), 64'd0);
        check("full_count4", 64'(fifo_count), 64'd4);
      end
      if (k == 9)  check("full_ready9", 64'(spu_ready), 64'd0);
      if (k == 10) check("full_ready10", 64'(spu_ready), 64'd1);
      acc = spu_valid && spu_ready;
      tick();
      if (acc) sp++;
      if (rf_we) begin
        if (rf_waddr == 5'd5) pcnt++;
        else begin
          check($sformatf("full_order_%0d", got), 64'({rf_waddr, rf_wdata}),
                64'({5'(10 + got), 32'(32'hA0 + got)}));
          got++;
        end
      end
    end
    spu_valid = 1'b0;
    check("full_spu_writes",  64'(got), 64'd5);
    check("full_pipe_writes", 64'(pcnt), 64'd10);
    check("full_drained",     64'(fifo_count), 64'd0);

    // Simultaneous push and pop at count 2
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd7; pipe_wr_data = 32'd77;
    spu_valid = 1'b1; spu_addr = 5'd27; spu_data = 32'hD0;
    tick();
    spu_addr = 5'd3; spu_data = 32'hD1;
    tick();
    pipe_wr_en = 1'b0; spu_addr = 5'd27; spu_data = 32'hD2;
    #1;
    check("pp_count_before", 64'(fifo_count), 64'd2);
    check("pp_mask_before",  64'(pending_mask), 64'h0800_0008);
    tick();
    spu_valid = 1'b0;
    #1;
    check("pp_count_after", 64'(fifo_count), 64'd2);
    check("pp_mask_after",  64'(pending_mask), 64'h0800_0008);
    check("pp_rf0", rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd27, 32'hD0));
    tick();
    check("pp_rf1",   rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd3, 32'hD1));
    check("pp_mask1", 64'(pending_mask), 64'h0800_0008);
    tick();
    check("pp_rf2",   rfv(rf_we, rf_waddr, rf_wdata), rfv(1'b1, 5'd27, 32'hD2));
    check("pp_mask2", 64'(pending_mask), 64'h0800_0000);
    tick();
    check("pp_mask3",  64'(pending_mask), 64'd0);
    check("pp_count3", 64'(fifo_count), 64'd0);
    check("pp_we3",    64'(rf_we), 64'd0);

`ifdef SPU_WB_STATS_EN
    // Statistics: 3 forced slots, 7 full cycles
    rst_n = 1'b0;
    #2 check("stat_rst", 64'({stat_force_cnt, stat_full_cnt}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    sp = 0;
    for (int k = 0; k < 28; k++) begin
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'h66;
      spu_valid = (k <= 11); spu_addr = 5'(16 + sp); spu_data = 32'(sp);
      #1 acc = spu_valid && spu_ready;
      tick();
      if (acc) sp++;
    end
    pipe_wr_en = 1'b0; spu_valid = 1'b0;
    check("stat_force", 64'(stat_force_cnt), 64'd3);
    check("stat_full",  64'(stat_full_cnt), 64'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spu_wb_arbiter.md
Name: spu_wb_arbiter

Overview:
- Shares the single register-file write port between the CPU writeback stage (ALU/MEM/PC/FLAGS results) and the asynchronous-latency SPU string unit, whose result normally targets r27.
- SPU results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so that SPU results cannot wait forever.
- Exports a pending-register mask so decode can interlock on registers awaiting an SPU write.

Parameters:
- DEPTH, 4: SPU result FIFO entries (power of two, ≥2).
- MAX_STARVE, 8: consecutive pipeline-owned write cycles with a non-empty FIFO before a forced SPU slot (≥1).
- DW, 32: data width.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wr_en  in  1  writeback stage requests a register write this cycle.
- pipe_wr_addr  in  5  destination register.
- pipe_wr_data  in  DW  write data.
- pipe_stall  out  1  combinational; writeback must hold its request this cycle.
- spu_valid  in  1  SPU result available.
- spu_addr  in  5  SPU destination register (27 for string ops).
- spu_data  in  DW  SPU result.
- spu_ready  out  1  FIFO can accept; transfer occurs when spu_valid && spu_ready.
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  DW  registered write data.
- pending_mask  out  32  bit i set while any valid FIFO entry targets register i.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, fifo empty, fifo_count=0, pending_mask=0, spu_ready=1, pipe_stall=0, starve_cnt=0, state=NORMAL.
- Latency: the winning request in cycle N appears on rf_* in cycle N+1 for exactly one cycle. rf_we=0 when no request wins.
- spu_ready = (count<DEPTH). No push-through when full, even if a pop occurs in the same cycle.
- A pushed entry is poppable at the earliest in the next cycle. Empty-FIFO SPU latency is push N, rf_we N+2.
- FSM NORMAL:
  - pipe_wr_en=1: pipeline wins, pipe_stall=0. If the FIFO is non-empty, starve_cnt++.
  - pipe_wr_en=0 and FIFO non-empty: pop head onto rf_*, starve_cnt=0.
  - FIFO empty: starve_cnt=0.
  - starve_cnt reaching MAX_STARVE with the FIFO non-empty: next state FORCE.
- FSM FORCE (exactly one cycle):
  - pop head onto rf_*, pipe_stall = pipe_wr_en, starve_cnt=0, then return to NORMAL.
  - The FIFO is non-empty in FORCE by construction.
- Simultaneous push and pop when not full: count unchanged, order preserved (strict FIFO).
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- pending_mask is the combinational OR of one-hot(addr) over valid entries. It clears the cycle after the last matching entry pops.
- The block does not resolve write-after-write hazards; decode must stall on pending_mask. An address collision between the winning pipe write and a pending entry is allowed; the later write wins in RF order.
- Reset mid-operation: FIFO contents are discarded, and an in-flight rf_we drops immediately (asynchronous).

Optional Feature:
- SPU_WB_STATS_EN defined:
  - adds outputs stat_force_cnt[15:0] (FORCE entries) and stat_full_cnt[15:0] (cycles with spu_valid && !spu_ready).
  - both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package spu_wb_pkg holds:
  - typedef wb_req_t {en, addr[4:0], data[DW-1:0]};
  - localparam SPU_DEST_REG = 5'd27;
  - FSM state enum {NORMAL, FORCE}.
- One sub-module, spu_wb_fifo: a parameterised synchronous FIFO exposing push, pop, head, count, full, empty and a per-entry valid/addr vector for pending_mask.
- The arbiter FSM and the output registers stay in the top module.

Test Plan:
- Reset then idle: rf_we=0, spu_ready=1, pending_mask=0; assert rst_n low mid-write → rf_we=0 immediately.
- Single SPU push addr=27 data=0xDEADBEEF with the pipe idle → rf_we=1, rf_waddr=27, rf_wdata=0xDEADBEEF two cycles later; pending_mask[27] high for exactly 2 cycles.
- Pipe writes every cycle (addr=5) with 1 SPU entry queued, MAX_STARVE=8 → pipe_stall=1 in cycle 9 and the SPU entry written in cycle 10; no pipe write lost, order preserved.
- Push 5 SPU results (DEPTH=4) while the pipe is busy → spu_ready low after 4; the 5th is held by the SPU, accepted after the first pop; all 5 written in order.
- Simultaneous push and pop at count=2 → count stays 2; pending_mask tracks both addresses (27, 3) correctly.
- With SPU_WB_STATS_EN: drive 3 forced slots and 7 full-stall cycles → stat_force_cnt=3, stat_full_cnt=7.
